// File: rtl/branch_predictor_if.sv
// Fetch/EX bundle between the pipeline and the branch predictor.
// The master is the pipeline side; the slave is the predictor.
interface branch_predictor_if;
    logic        suspend;

    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        pred_error;
    logic [31:0] redirect_pc;

    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    modport master (
        output suspend, if_pc,
        output ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, pred_error, redirect_pc, br_cnt, miss_cnt
    );

    modport slave (
        input  suspend, if_pc,
        input  ex_valid, ex_pc, ex_taken, ex_target, ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, pred_error, redirect_pc, br_cnt, miss_cnt
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, combinational
// lookup for fetch, registered update from EX, and mispredict statistics.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 30 - IDX_W
) (
    input  logic              cpu_clk,
    input  logic              cpu_rstn,
    branch_predictor_if.slave bp
);

    localparam int ENTRIES = 2 ** IDX_W;

    logic [ENTRIES-1:0] valid_q;
    logic [1:0]         cnt_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [29:0]        target_q [ENTRIES];
    logic [31:0]        br_cnt_q;
    logic [31:0]        miss_cnt_q;

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic             lk_taken;

    logic [IDX_W-1:0] ex_idx;
    logic [TAG_W-1:0] ex_tag;
    logic             ex_hit;
    logic             upd;
    logic             dir_wrong;
    logic             tgt_wrong;
    logic             mispredict;

    // Lookup reads the array as it stands; a same-cycle update is not forwarded.
    always_comb begin
        lk_idx   = bp.if_pc[IDX_W+1:2];
        lk_tag   = bp.if_pc[31:IDX_W+2];
        lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken = lk_hit && cnt_q[lk_idx][1];
    end

    assign bp.pred_taken  = lk_taken;
    assign bp.pred_target = lk_taken ? {target_q[lk_idx], 2'b00} : bp.if_pc + 32'd4;

    always_comb begin
        ex_idx     = bp.ex_pc[IDX_W+1:2];
        ex_tag     = bp.ex_pc[31:IDX_W+2];
        ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
        upd        = bp.ex_valid && !bp.suspend;
        dir_wrong  = bp.ex_taken != bp.ex_pred_taken;
        tgt_wrong  = bp.ex_taken && (bp.ex_target != bp.ex_pred_target);
        mispredict = upd && (dir_wrong || tgt_wrong);
    end

    assign bp.pred_error  = mispredict;
    assign bp.redirect_pc = bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4;

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= 2'b00;
            end
        end else if (upd) begin
            if (ex_hit) begin
                if (bp.ex_taken) begin
                    if (cnt_q[ex_idx] != 2'b11) begin
                        cnt_q[ex_idx] <= cnt_q[ex_idx] + 2'd1;
                    end
                end else if (cnt_q[ex_idx] != 2'b00) begin
                    cnt_q[ex_idx] <= cnt_q[ex_idx] - 2'd1;
                end
            end else if (bp.ex_taken) begin
                valid_q[ex_idx] <= 1'b1;
                cnt_q[ex_idx]   <= 2'b10;
            end
        end
    end

    // A taken resolution writes tag and target on both hit and allocate;
    // on a hit the tag is unchanged, so one write path covers both cases.
    always_ff @(posedge cpu_clk) begin
        if (upd && bp.ex_taken) begin
            tag_q[ex_idx]    <= ex_tag;
            target_q[ex_idx] <= bp.ex_target[31:2];
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            br_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (upd) begin
                br_cnt_q <= br_cnt_q + 32'd1;
            end
            if (mispredict) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign bp.br_cnt   = br_cnt_q;
    assign bp.miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a table-level model checked every
// negedge, plus hand-computed literal checks along the scenario.
module tb_branch_predictor;

    logic cpu_clk;
    logic cpu_rstn;
    logic run;
    int   n_vec;
    int   n_err;

    branch_predictor_if bp ();

    branch_predictor dut (
        .cpu_clk (cpu_clk),
        .cpu_rstn(cpu_rstn),
        .bp      (bp)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: each slot remembers the full branch PC tag and the full target
    // address; the direction confidence is an integer 0..3.
    bit          m_valid [64];
    logic [31:0] m_tag   [64];
    logic [31:0] m_tgt   [64];
    int          m_cnt   [64];
    logic [31:0] m_br;
    logic [31:0] m_miss;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'd64);
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[slot(pc)] && (m_tag[slot(pc)] == pc / 32'd256);
    endfunction

    function automatic bit m_pred_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[slot(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_pred_target(input logic [31:0] pc);
        return m_pred_taken(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
    endfunction

    function automatic bit m_error();
        if (!bp.ex_valid || bp.suspend) return 1'b0;
        if (bp.ex_taken != bp.ex_pred_taken) return 1'b1;
        return bp.ex_taken && (bp.ex_target != bp.ex_pred_target);
    endfunction

    always @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            for (int i = 0; i < 64; i++) begin
                m_valid[i] = 1'b0;
                m_cnt[i]   = 0;
            end
            m_br   = 0;
            m_miss = 0;
        end else if (bp.ex_valid && !bp.suspend) begin
            int s;
            s = slot(bp.ex_pc);
            if (m_error()) m_miss = m_miss + 1;
            m_br = m_br + 1;
            if (m_hit(bp.ex_pc)) begin
                if (bp.ex_taken) begin
                    m_cnt[s] = (m_cnt[s] == 3) ? 3 : m_cnt[s] + 1;
                    m_tgt[s] = bp.ex_target & 32'hffff_fffc;
                end else begin
                    m_cnt[s] = (m_cnt[s] == 0) ? 0 : m_cnt[s] - 1;
                end
            end else if (bp.ex_taken) begin
                m_valid[s] = 1'b1;
                m_tag[s]   = bp.ex_pc / 32'd256;
                m_tgt[s]   = bp.ex_target & 32'hffff_fffc;
                m_cnt[s]   = 2;
            end
        end
    end

    always @(negedge cpu_clk) begin
        if (run) begin
            chk("cmp_pred_taken", {31'd0, bp.pred_taken}, {31'd0, m_pred_taken(bp.if_pc)});
            chk("cmp_pred_target", bp.pred_target, m_pred_target(bp.if_pc));
            chk("cmp_pred_error", {31'd0, bp.pred_error}, {31'd0, m_error()});
            if (m_error())
                chk("cmp_redirect", bp.redirect_pc,
                    bp.ex_taken ? bp.ex_target : bp.ex_pc + 32'd4);
            chk("cmp_br_cnt", bp.br_cnt, m_br);
            chk("cmp_miss_cnt", bp.miss_cnt, m_miss);
        end
    end

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic ex_set(input logic v, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bp.ex_valid       = v;
        bp.ex_pc          = pc;
        bp.ex_taken       = tk;
        bp.ex_target      = tgt;
        bp.ex_pred_taken  = ptk;
        bp.ex_pred_target = ptgt;
    endtask

    task automatic ex_idle();
        ex_set(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic look(input string name, input logic [31:0] pc,
                        input logic tk, input logic [31:0] tgt);
        bp.if_pc = pc;
        #1;
        chk({name, "_taken"}, {31'd0, bp.pred_taken}, {31'd0, tk});
        chk({name, "_target"}, bp.pred_target, tgt);
    endtask

    task automatic stats(input string name, input logic [31:0] br, input logic [31:0] miss);
        chk({name, "_br"}, bp.br_cnt, br);
        chk({name, "_miss"}, bp.miss_cnt, miss);
    endtask

    localparam logic [31:0] B0  = 32'h1c00_0010;
    localparam logic [31:0] B0F = 32'h1c00_0014;
    localparam logic [31:0] T0  = 32'h1c00_0100;
    localparam logic [31:0] T1  = 32'h1c00_0180;
    localparam logic [31:0] B1  = 32'h1c00_0110;
    localparam logic [31:0] T2  = 32'h1c00_0200;

    initial begin
        n_vec       = 0;
        n_err       = 0;
        run         = 1'b0;
        cpu_rstn    = 1'b0;
        bp.suspend  = 1'b0;
        bp.if_pc    = 32'h1c00_0000;
        ex_idle();
        #3;
        look("rst_lookup", 32'h1c00_0000, 1'b0, 32'h1c00_0004);
        stats("rst", 32'd0, 32'd0);
        #9 cpu_rstn = 1'b1;
        run = 1'b1;
        tick();

        // Allocation, with a same-cycle lookup of the same slot.
        ex_set(1'b1, B0, 1'b1, T0, 1'b0, B0F);
        look("same_cycle", B0, 1'b0, B0F);
        chk("alloc_err", {31'd0, bp.pred_error}, 32'd1);
        chk("alloc_redirect", bp.redirect_pc, T0);
        tick();
        ex_idle();
        look("after_alloc", B0, 1'b1, T0);
        stats("alloc", 32'd1, 32'd1);

        // Taken-predicted branch falls through: 10 -> 01.
        ex_set(1'b1, B0, 1'b0, T0, 1'b1, T0);
        #1;
        chk("nt1_err", {31'd0, bp.pred_error}, 32'd1);
        chk("nt1_redirect", bp.redirect_pc, B0F);
        tick();
        look("cnt01", B0, 1'b0, B0F);
        ex_set(1'b1, B0, 1'b0, T0, 1'b0, B0F);
        #1;
        chk("nt2_err", {31'd0, bp.pred_error}, 32'd0);
        tick();
        tick();
        ex_idle();
        look("cnt00_sat", B0, 1'b0, B0F);
        stats("nt", 32'd4, 32'd2);

        // Four taken: 00 -> 01 -> 10 -> 11 -> 11.
        for (int k = 0; k < 4; k++) begin
            ex_set(1'b1, B0, 1'b1, T0, k >= 2, (k >= 2) ? T0 : B0F);
            tick();
        end
        ex_idle();
        look("cnt11", B0, 1'b1, T0);
        stats("up", 32'd8, 32'd4);

        // Hit, taken to a new target: target rewritten.
        ex_set(1'b1, B0, 1'b1, T1, 1'b1, T0);
        #1;
        chk("tgt_err", {31'd0, bp.pred_error}, 32'd1);
        chk("tgt_redirect", bp.redirect_pc, T1);
        tick();
        ex_set(1'b1, B0, 1'b0, T1, 1'b1, T1);
        tick();
        ex_idle();
        look("cnt10_newtgt", B0, 1'b1, T1);
        stats("tgt", 32'd10, 32'd6);

        // Aliasing branch in slot 4 replaces the entry.
        ex_set(1'b1, B1, 1'b1, T2, 1'b0, B1 + 32'd4);
        tick();
        ex_idle();
        look("alias_old", B0, 1'b0, B0F);
        look("alias_new", B1, 1'b1, T2);

        // Held mispredict under suspend.
        bp.suspend = 1'b1;
        ex_set(1'b1, 32'h1c00_0020, 1'b1, 32'h1c00_0300, 1'b0, 32'h1c00_0024);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("stall_err", {31'd0, bp.pred_error}, 32'd0);
            tick();
            stats("stall", 32'd11, 32'd7);
        end
        bp.suspend = 1'b0;
        #1;
        chk("release_err", {31'd0, bp.pred_error}, 32'd1);
        chk("release_redirect", bp.redirect_pc, 32'h1c00_0300);
        tick();
        ex_idle();
        stats("release", 32'd12, 32'd8);
        look("release_lookup", 32'h1c00_0020, 1'b1, 32'h1c00_0300);

        // Miss, not taken: statistics only.
        ex_set(1'b1, 32'h1c00_0030, 1'b0, 32'h0, 1'b0, 32'h1c00_0034);
        tick();
        ex_idle();
        look("miss_nt", 32'h1c00_0030, 1'b0, 32'h1c00_0034);
        stats("miss_nt", 32'd13, 32'd8);

        // Asynchronous reset between clock edges.
        #1 cpu_rstn = 1'b0;
        #1;
        look("async_rst", B1, 1'b0, B1 + 32'd4);
        stats("async_rst", 32'd0, 32'd0);
        tick();
        cpu_rstn = 1'b1;
        tick();
        look("post_rst", 32'h1c00_0020, 1'b0, 32'h1c00_0024);
        tick();

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
